perf_snapshot_streamer: RTL

- Read-side companion to the performance counter.
- On a snapshot request, captures blocks_processed and cycles_elapsed atomically in the same cycle.
- Serialises both values as a byte frame over a valid/ready stream to the debug/host link.
- Sits between the counter outputs and the top-level debug byte port.

---
 rtl/perf_pkg.sv | 17 +
 rtl/perf_byte_mux.sv | 42 ++++
 rtl/perf_snapshot_streamer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/perf_pkg.sv
// Shared types and helpers for the performance snapshot streamer.
// Optional feature macro: PERF_SNAP_CHECKSUM_EN (appends an XOR checksum byte).
package perf_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

   // Frame is header + seq + two counter fields, plus one byte when the checksum is on.
   function automatic int unsigned frame_len(input int unsigned counter_width, input bit csum_en);
      return 2 + 2 * (counter_width / 8) + (csum_en ? 1 : 0);
   endfunction

endpackage

// File: rtl/perf_byte_mux.sv
// Selects the frame byte addressed by byte_idx_i from header, seq and the snapshots.
// Optional feature macro: PERF_SNAP_CHECKSUM_EN (last byte is the XOR of all earlier bytes).
module perf_byte_mux #(
   parameter int unsigned COUNTER_WIDTH = 32,
   parameter int unsigned IDX_W         = 4
) (
   input  logic [IDX_W-1:0]         byte_idx_i,
   input  logic [7:0]               header_i,
   input  logic [7:0]               seq_i,
   input  logic [COUNTER_WIDTH-1:0] blk_i,
   input  logic [COUNTER_WIDTH-1:0] cyc_i,
   output logic [7:0]               byte_o
);
   localparam int unsigned NB = COUNTER_WIDTH / 8;

`ifdef PERF_SNAP_CHECKSUM_EN
   logic [7:0] csum;

   // Checksum is derived from the snapshot registers, so it is stable for the whole frame.
   always_comb begin
      csum = header_i ^ seq_i;
      for (int k = 0; k < NB; k++) begin
         csum = csum ^ blk_i[8*k +: 8] ^ cyc_i[8*k +: 8];
      end
   end
`endif

   // Byte select: header, seq, blocks LSB first, cycles LSB first.
   always_comb begin
      byte_o = 8'h00;
      if (byte_idx_i == IDX_W'(0)) byte_o = header_i;
      if (byte_idx_i == IDX_W'(1)) byte_o = seq_i;
      for (int k = 0; k < NB; k++) begin
         if (byte_idx_i == IDX_W'(2 + k))      byte_o = blk_i[8*k +: 8];
         if (byte_idx_i == IDX_W'(2 + NB + k)) byte_o = cyc_i[8*k +: 8];
      end
`ifdef PERF_SNAP_CHECKSUM_EN
      if (byte_idx_i == IDX_W'(2 + 2*NB)) byte_o = csum;
`endif
   end

endmodule

// File: rtl/perf_snapshot_streamer.sv
// Captures the block/cycle counters atomically on request and streams them as a byte frame.
// Optional feature macro: PERF_SNAP_CHECKSUM_EN (adds a trailing XOR checksum byte).
//
// state | meaning
// IDLE  | no frame in flight; a request captures the counters and starts a frame
// SEND  | presenting frame bytes; advances on each handshake, restarts on a request at the last byte
module perf_snapshot_streamer
   import perf_pkg::*;
#(
   parameter int unsigned COUNTER_WIDTH = 32,
   parameter logic [7:0]  HEADER_BYTE   = DEFAULT_HEADER
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     snap_req,
   input  logic [COUNTER_WIDTH-1:0] blocks_processed,
   input  logic [COUNTER_WIDTH-1:0] cycles_elapsed,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               out_data,
   output logic                     out_last,
   output logic                     busy,
   output logic [7:0]               drop_cnt
);
`ifdef PERF_SNAP_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif
   localparam int unsigned FRAME_LEN = frame_len(COUNTER_WIDTH, CSUM_EN);
   localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   state_e                   state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [7:0]               seq_q, seq_d;
   logic [7:0]               drop_q, drop_d;
   logic [COUNTER_WIDTH-1:0] blk_q, blk_d;
   logic [COUNTER_WIDTH-1:0] cyc_q, cyc_d;
   logic [7:0]               mux_byte;
   logic                     sending;
   logic                     hs;
   logic                     at_last;

   assign sending   = (state_q == SEND);
   assign at_last   = (idx_q == LAST_IDX);
   assign hs        = sending && out_ready;
   assign out_valid = sending;
   assign busy      = sending;
   assign out_last  = sending && at_last;
   // Gate with the state so the byte port reads zero whenever nothing is offered.
   assign out_data  = sending ? mux_byte : 8'h00;
   assign drop_cnt  = drop_q;

   perf_byte_mux #(
      .COUNTER_WIDTH(COUNTER_WIDTH),
      .IDX_W        (IDX_W)
   ) u_byte_mux (
      .byte_idx_i(idx_q),
      .header_i  (HEADER_BYTE),
      .seq_i     (seq_q),
      .blk_i     (blk_q),
      .cyc_i     (cyc_q),
      .byte_o    (mux_byte)
   );

   // Next-state: capture, byte advance, seq wrap, back-to-back restart and drop counting.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      seq_d   = seq_q;
      drop_d  = drop_q;
      blk_d   = blk_q;
      cyc_d   = cyc_q;
      unique case (state_q)
         IDLE: begin
            if (snap_req) begin
               blk_d   = blocks_processed;
               cyc_d   = cycles_elapsed;
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (hs && at_last) begin
               seq_d = seq_q + 8'd1;
               if (snap_req) begin
                  blk_d = blocks_processed;
                  cyc_d = cycles_elapsed;
                  idx_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (hs) idx_d = idx_q + IDX_W'(1);
               if (snap_req && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and snapshot registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         seq_q   <= 8'h00;
         drop_q  <= 8'h00;
         blk_q   <= '0;
         cyc_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         seq_q   <= seq_d;
         drop_q  <= drop_d;
         blk_q   <= blk_d;
         cyc_q   <= cyc_d;
      end
   end

endmodule
